// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit bus controller.
// Decodes one memory op per start_i pulse, performs a single request/grant
// bus access and, for loads, waits for read data, then extracts and
// sign/zero-extends the result.
// Optional feature: define LSU_MISALIGN_CHK_EN to reject misaligned half/word
// accesses with err_o instead of silently aligning them.
module lsu_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            inst_lb_i,
  input  logic            inst_lh_i,
  input  logic            inst_lw_i,
  input  logic            inst_lbu_i,
  input  logic            inst_lhu_i,
  input  logic            inst_sb_i,
  input  logic            inst_sh_i,
  input  logic            inst_sw_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] rs2_rd_data_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rd_data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            rd_wr_en_o,
  output logic [XLEN-1:0] rd_wr_data_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t          state_q, state_d;

  // decoded op for the current start_i
  logic            dec_valid;
  logic            dec_store;
  logic            dec_unsigned;
  size_t           dec_size;
  logic            dec_misalign;

  // latched op
  logic            op_store_q;
  logic            op_unsigned_q;
  size_t           op_size_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] rd_data_q;
`ifdef LSU_MISALIGN_CHK_EN
  logic            err_q;
`endif

  logic [1:0]      offset;
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] load_result;
  logic            accept;

  // Priority decode of the op flags: lw > lh > lhu > lb > lbu > sw > sh > sb
  always_comb begin
    dec_valid    = 1'b1;
    dec_store    = 1'b0;
    dec_unsigned = 1'b0;
    dec_size     = SZ_WORD;
    if (inst_lw_i) begin
      dec_size = SZ_WORD;
    end else if (inst_lh_i) begin
      dec_size = SZ_HALF;
    end else if (inst_lhu_i) begin
      dec_size     = SZ_HALF;
      dec_unsigned = 1'b1;
    end else if (inst_lb_i) begin
      dec_size = SZ_BYTE;
    end else if (inst_lbu_i) begin
      dec_size     = SZ_BYTE;
      dec_unsigned = 1'b1;
    end else if (inst_sw_i) begin
      dec_size  = SZ_WORD;
      dec_store = 1'b1;
    end else if (inst_sh_i) begin
      dec_size  = SZ_HALF;
      dec_store = 1'b1;
    end else if (inst_sb_i) begin
      dec_size  = SZ_BYTE;
      dec_store = 1'b1;
    end else begin
      dec_valid = 1'b0;
    end
  end

  // Misalignment detection (only meaningful when the check is built in)
  always_comb begin
`ifdef LSU_MISALIGN_CHK_EN
    dec_misalign = ((dec_size == SZ_HALF) && addr_i[0]) ||
                   ((dec_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
`else
    dec_misalign = 1'b0;
`endif
  end

  assign accept = (state_q == IDLE) && start_i && dec_valid;

  // Byte offset inside the word; half/word offsets are forced aligned
  always_comb begin
    case (op_size_q)
      SZ_BYTE: offset = addr_q[1:0];
      SZ_HALF: offset = {addr_q[1], 1'b0};
      default: offset = 2'b00;
    endcase
  end

  // Load extraction: shift the addressed lane down, then extend
  always_comb begin
    rd_shifted = mem_rd_data_i >> {offset, 3'b000};
    case (op_size_q)
      SZ_BYTE: load_result = op_unsigned_q ? {{(XLEN-8){1'b0}}, rd_shifted[7:0]}
                                           : {{(XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_HALF: load_result = op_unsigned_q ? {{(XLEN-16){1'b0}}, rd_shifted[15:0]}
                                           : {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_result = rd_shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = dec_misalign ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d = op_store_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on accept, load result capture on read data in WAIT
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      op_store_q    <= 1'b0;
      op_unsigned_q <= 1'b0;
      op_size_q     <= SZ_BYTE;
      addr_q        <= '0;
      data_q        <= '0;
      rd_data_q     <= '0;
`ifdef LSU_MISALIGN_CHK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_store_q    <= dec_store;
        op_unsigned_q <= dec_unsigned;
        op_size_q     <= dec_size;
        addr_q        <= addr_i;
        data_q        <= rs2_rd_data_i;
        rd_data_q     <= '0;
`ifdef LSU_MISALIGN_CHK_EN
        err_q         <= dec_misalign;
`endif
      end else if ((state_q == WAIT) && mem_rvalid_i) begin
        rd_data_q <= load_result;
      end
    end
  end

  // Outputs decoded from state; bus fields are only driven while requesting
  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_be_o      = '0;
    mem_wr_data_o = '0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    rd_wr_en_o    = 1'b0;
    rd_wr_data_o  = '0;
    busy_o        = (state_q != IDLE);
    case (state_q)
      REQ: begin
        mem_req_o  = 1'b1;
        mem_we_o   = op_store_q;
        mem_addr_o = {addr_q[XLEN-1:2], 2'b00};
        case (op_size_q)
          SZ_BYTE: begin
            mem_be_o      = 4'b0001 << offset;
            mem_wr_data_o = {(XLEN/8){data_q[7:0]}};
          end
          SZ_HALF: begin
            mem_be_o      = 4'b0011 << offset;
            mem_wr_data_o = {(XLEN/16){data_q[15:0]}};
          end
          default: begin
            mem_be_o      = 4'b1111;
            mem_wr_data_o = data_q;
          end
        endcase
      end
      DONE: begin
        done_o = 1'b1;
`ifdef LSU_MISALIGN_CHK_EN
        err_o      = err_q;
        rd_wr_en_o = !op_store_q && !err_q;
`else
        rd_wr_en_o = !op_store_q;
`endif
        if (rd_wr_en_o) begin
          rd_wr_data_o = rd_data_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table, randomized transactions against a
// byte-level reference model, and hand-written reset / busy sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  flg;  // bit0 lw,1 lh,2 lhu,3 lb,4 lbu,5 sw,6 sh,7 sb
  logic [31:0] addr, rs2;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_be;
  logic        busy, done, err, rd_wr_en;
  logic [31:0] rd_wr_data;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LSU_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  lsu_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .inst_lb_i(flg[3]), .inst_lh_i(flg[1]), .inst_lw_i(flg[0]),
    .inst_lbu_i(flg[4]), .inst_lhu_i(flg[2]), .inst_sb_i(flg[7]),
    .inst_sh_i(flg[6]), .inst_sw_i(flg[5]),
    .addr_i(addr), .rs2_rd_data_i(rs2),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wr_data_o(mem_wr_data),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rd_data_i(mem_rd_data),
    .busy_o(busy), .done_o(done), .err_o(err),
    .rd_wr_en_o(rd_wr_en), .rd_wr_data_o(rd_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".done"}, 32'(done), 0);
    chk({nm, ".err"}, 32'(err), 0);
    chk({nm, ".req"}, 32'(mem_req), 0);
    chk({nm, ".we"}, 32'(mem_we), 0);
    chk({nm, ".addr"}, mem_addr, 0);
    chk({nm, ".be"}, 32'(mem_be), 0);
    chk({nm, ".wdata"}, mem_wr_data, 0);
    chk({nm, ".rd_en"}, 32'(rd_wr_en), 0);
    chk({nm, ".rd_data"}, rd_wr_data, 0);
  endtask

  // Reference model: RISC-V semantics from byte sizes and plain arithmetic
  function automatic void model(input logic [7:0] f, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] rdat,
                                output logic st, output logic [31:0] eaddr,
                                output logic [3:0] ebe, output logic [31:0] ewd,
                                output logic [31:0] erd, output logic eerr);
    int op = 0;
    int n;
    int off;
    logic sgn;
    logic [31:0] mask, v;
    while (op < 8 && !f[op]) op++;
    n    = (op == 0 || op == 5) ? 4 : (op == 1 || op == 2 || op == 6) ? 2 : 1;
    sgn  = (op == 1 || op == 3);
    st   = (op >= 5);
    off  = int'(a % 4);
    off  = off - (off % n);
    eaddr = a & ~32'h3;
    ebe  = 4'(((1 << n) - 1) << off);
    for (int b = 0; b < 4; b++) ewd[8*b +: 8] = d[8*(b % n) +: 8];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
    v    = (rdat >> (8 * off)) & mask;
    if (sgn && v[8*n-1]) v = v | ~mask;
    eerr = MIS && (n > 1) && ((a % n) != 0);
    erd  = (st || eerr) ? 32'h0 : v;
  endfunction

  // Drive one transaction starting in the next cycle and check every cycle
  task automatic run_txn(input string nm, input logic [7:0] f, input logic [31:0] a,
                         input logic [31:0] d, input int gd, input int rvd,
                         input logic [31:0] rdat, input logic st,
                         input logic [31:0] eaddr, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] erd, input logic eerr);
    @(negedge clk);
    chk({nm, ".idle"}, 32'(busy), 0);
    start = 1'b1; flg = f; addr = a; rs2 = d;
    mem_rvalid = 1'($urandom_range(0, 1)); mem_rd_data = $urandom;
    @(negedge clk);
    start = 1'b0; flg = '0; addr = $urandom; rs2 = $urandom; mem_rvalid = 1'b0;
    if (eerr) begin
      chk({nm, ".err"}, 32'(err), 1);
      chk({nm, ".done"}, 32'(done), 1);
      chk({nm, ".req"}, 32'(mem_req), 0);
      chk({nm, ".rd_en"}, 32'(rd_wr_en), 0);
      chk({nm, ".rd_data"}, rd_wr_data, 0);
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      chk({nm, ".req"}, 32'(mem_req), 1);
      chk({nm, ".we"}, 32'(mem_we), 32'(st));
      chk({nm, ".addr"}, mem_addr, eaddr);
      chk({nm, ".be"}, 32'(mem_be), 32'(ebe));
      if (st) chk({nm, ".wdata"}, mem_wr_data, ewd);
      chk({nm, ".done_early"}, 32'(done), 0);
      mem_gnt = (i == gd);
      mem_rvalid = 1'($urandom_range(0, 1)); mem_rd_data = $urandom;
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!st) begin
      for (int i = 0; i <= rvd; i++) begin
        chk({nm, ".wait_req"}, 32'(mem_req), 0);
        chk({nm, ".wait_busy"}, 32'(busy), 1);
        chk({nm, ".wait_done"}, 32'(done), 0);
        mem_rvalid = (i == rvd);
        mem_rd_data = (i == rvd) ? rdat : $urandom;
        @(negedge clk);
      end
      mem_rvalid = 1'b0; mem_rd_data = $urandom;
    end
    chk({nm, ".done"}, 32'(done), 1);
    chk({nm, ".err"}, 32'(err), 0);
    chk({nm, ".req"}, 32'(mem_req), 0);
    chk({nm, ".rd_en"}, 32'(rd_wr_en), 32'(!st));
    chk({nm, ".rd_data"}, rd_wr_data, erd);
  endtask

  typedef struct {
    logic [7:0]  f;
    logic        st;
    logic [31:0] a, d;
    int          gd, rvd;
    logic [31:0] rdat, eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd;
    logic        eerr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst_n = 1'b0; start = 1'b0; flg = '0; addr = '0; rs2 = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rd_data = '0;

    // f, st, addr, rs2, gnt_dly, rv_dly, rdata, exp addr, be, wdata, rd, err
    tbl[0]  = '{8'h20, 1'b1, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0, 32'h104, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{8'h08, 1'b0, 32'h203, 32'h0, 3, 2, 32'h80FF1234, 32'h200, 4'h8, 32'h0, 32'hFFFFFF80, 1'b0};
    tbl[2]  = '{8'h10, 1'b0, 32'h203, 32'h0, 3, 2, 32'h80FF1234, 32'h200, 4'h8, 32'h0, 32'h00000080, 1'b0};
    tbl[3]  = '{8'h40, 1'b1, 32'h10A, 32'h0000ABCD, 1, 0, 32'h0, 32'h108, 4'hC, 32'hABCDABCD, 32'h0, 1'b0};
    tbl[4]  = '{8'h04, 1'b0, 32'h10A, 32'h0, 0, 1, 32'hABCD0000, 32'h108, 4'hC, 32'h0, 32'h0000ABCD, 1'b0};
    tbl[5]  = '{8'h01, 1'b0, 32'h3, 32'h0, 0, 0, 32'h12345678, 32'h0, 4'hF, 32'h0, 32'h12345678, MIS};
    tbl[6]  = '{8'h80, 1'b1, 32'h7, 32'h11223344, 0, 0, 32'h0, 32'h4, 4'h8, 32'h44444444, 32'h0, 1'b0};
    tbl[7]  = '{8'h02, 1'b0, 32'h2, 32'h0, 0, 0, 32'h80017FFF, 32'h0, 4'hC, 32'h0, 32'hFFFF8001, 1'b0};
    tbl[8]  = '{8'h02, 1'b0, 32'h0, 32'h0, 2, 0, 32'h80017FFF, 32'h0, 4'h3, 32'h0, 32'h00007FFF, 1'b0};
    tbl[9]  = '{8'h08, 1'b0, 32'h1, 32'h0, 0, 3, 32'h00007F00, 32'h0, 4'h2, 32'h0, 32'h0000007F, 1'b0};
    tbl[10] = '{8'h83, 1'b0, 32'h1000, 32'h0, 0, 0, 32'hCAFEF00D, 32'h1000, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0};
    tbl[11] = '{8'h40, 1'b1, 32'h3, 32'h12345678, 0, 0, 32'h0, 32'h0, 4'hC, 32'h56785678, 32'h0, MIS};
    tbl[12] = '{8'hB0, 1'b0, 32'h2, 32'h0, 1, 1, 32'h00AB0000, 32'h0, 4'h4, 32'h0, 32'h000000AB, 1'b0};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].d, tbl[i].gd, tbl[i].rvd,
              tbl[i].rdat, tbl[i].st, tbl[i].eaddr, tbl[i].ebe, tbl[i].ewd, tbl[i].erd, tbl[i].eerr);
    end

    // Randomized transactions against the model, including extra lower-priority flags
    for (int i = 0; i < 150; i++) begin
      int op;
      logic [7:0] f;
      logic [31:0] a, d, rdat, eaddr, ewd, erd;
      logic [3:0] ebe;
      logic st, eerr;
      op = $urandom_range(0, 7);
      f = 8'(1 << op);
      if ($urandom_range(0, 3) == 0) f = f | (8'($urandom) & ~8'((2 << op) - 1));
      a = $urandom; d = $urandom; rdat = $urandom;
      model(f, a, d, rdat, st, eaddr, ebe, ewd, erd, eerr);
      run_txn($sformatf("rnd%0d", i), f, a, d, $urandom_range(0, 3), $urandom_range(0, 3),
              rdat, st, eaddr, ebe, ewd, erd, eerr);
    end

    // start_i with no op flag is ignored
    @(negedge clk);
    start = 1'b1; flg = '0; addr = 32'h40;
    @(negedge clk);
    start = 1'b0;
    chk("noflag.busy", 32'(busy), 0);
    chk("noflag.req", 32'(mem_req), 0);

    // start_i while busy is ignored
    start = 1'b1; flg = 8'h20; addr = 32'h20; rs2 = 32'h11;
    @(negedge clk);
    flg = 8'h01; addr = 32'h80;
    chk("busy.req", 32'(mem_req), 1);
    @(negedge clk);
    start = 1'b0; flg = '0;
    chk("busy.addr_held", mem_addr, 32'h20);
    chk("busy.we_held", 32'(mem_we), 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("busy.done", 32'(done), 1);
    @(negedge clk);
    chk_all_zero("busy.after");

    // Reset in WAIT, then a stale rvalid in IDLE is discarded
    start = 1'b1; flg = 8'h01; addr = 32'h44;
    @(negedge clk);
    start = 1'b0; flg = '0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw.busy", 32'(busy), 1);
    chk("rstw.req", 32'(mem_req), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("rstw.reset");
    mem_rvalid = 1'b1; mem_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk_all_zero("rstw.stale1");
    @(negedge clk);
    chk_all_zero("rstw.stale2");

    // Reset in REQ drops the request
    start = 1'b1; flg = 8'h80; addr = 32'h55; rs2 = 32'hA5;
    @(negedge clk);
    start = 1'b0; flg = '0;
    chk("rstr.req", 32'(mem_req), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("rstr.reset");

    // Normal operation after reset
    run_txn("post_rst", 8'h01, 32'h300, 32'h0, 0, 0, 32'h0BADF00D,
            1'b0, 32'h300, 4'hF, 32'h0, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    chk_all_zero("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
